mult_rr_arbiter: RTL

MULT_RR_ARBITER -- requirements
Module: mult_rr_arbiter

---
 rtl/mult_rr_arbiter_if.sv | 27 ++
 rtl/mult_rr_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/mult_rr_arbiter_if.sv
// Requester handshake, result slots and shared-multiplier bus for mult_rr_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the multiplier.
interface mult_rr_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [16*N_REQ-1:0] req_a;
   logic [16*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]    rsp_valid;
   logic [N_REQ-1:0]    rsp_ack;
   logic [16*N_REQ-1:0] rsp_c;
   logic [15:0]         mul_a;
   logic [15:0]         mul_b;
   logic [15:0]         mul_c;
   logic                busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ack, mul_c,
      input  req_ready, rsp_valid, rsp_c, mul_a, mul_b, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ack, mul_c,
      output req_ready, rsp_valid, rsp_c, mul_a, mul_b, busy
   );
endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one external Q8.8 multiplier among N_REQ requesters.
// A tag pipeline follows each operation so its product lands in the owner's result slot.
module mult_rr_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned MUL_LAT = 1
) (
   input logic              clk,
   input logic              rst,
   mult_rr_arbiter_if.slave bus
);
   localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned DEPTH = MUL_LAT + 1;

   logic [IW-1:0]       ptr;
   logic [DEPTH-1:0]    tag_vld;
   logic [IW-1:0]       tag_idx [DEPTH];
   logic [N_REQ-1:0]    in_flight;
   logic [N_REQ-1:0]    eligible;
   logic [N_REQ-1:0]    grant;
   logic [IW-1:0]       grant_idx;
   logic                xfer;
   logic                cap;
   logic [IW-1:0]       cap_idx;
   logic [15:0]         mul_a;
   logic [15:0]         mul_b;
   logic [N_REQ-1:0]    rsp_valid;
   logic [16*N_REQ-1:0] rsp_c;
   int unsigned         scan;

   always_comb begin
      in_flight = '0;
      for (int unsigned d = 0; d < DEPTH; d++)
         if (tag_vld[d]) in_flight[tag_idx[d]] = 1'b1;
   end

   assign eligible = bus.req_valid & ~in_flight & ~rsp_valid;

   // First eligible index at or above ptr, wrapping; suppressed while reset is held.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      xfer      = 1'b0;
      scan      = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan = 32'(ptr) + k;
         if (scan >= N_REQ) scan = scan - N_REQ;
         if (!rst && !xfer && eligible[IW'(scan)]) begin
            grant[IW'(scan)] = 1'b1;
            grant_idx        = IW'(scan);
            xfer             = 1'b1;
         end
      end
   end

   assign cap     = tag_vld[DEPTH-1];
   assign cap_idx = tag_idx[DEPTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         tag_vld   <= '0;
         rsp_valid <= '0;
         rsp_c     <= '0;
         for (int unsigned d = 0; d < DEPTH; d++) tag_idx[d] <= '0;
      end else begin
         tag_vld[0] <= xfer;
         tag_idx[0] <= grant_idx;
         for (int unsigned d = 1; d < DEPTH; d++) begin
            tag_vld[d] <= tag_vld[d-1];
            tag_idx[d] <= tag_idx[d-1];
         end
         if (xfer) begin
            ptr   <= (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
            mul_a <= bus.req_a[16*32'(grant_idx) +: 16];
            mul_b <= bus.req_b[16*32'(grant_idx) +: 16];
         end
         // Capture never targets an occupied slot, so it cannot race an ack.
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (cap && cap_idx == IW'(i)) begin
               rsp_valid[i]        <= 1'b1;
               rsp_c[16*i +: 16]   <= bus.mul_c;
            end else if (bus.rsp_ack[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst) cap |-> !rsp_valid[cap_idx]);

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_c     = rsp_c;
   assign bus.mul_a     = mul_a;
   assign bus.mul_b     = mul_b;
   assign bus.busy      = |tag_vld;
endmodule
